// File: rtl/ram_dp_clr.sv
// ram_dp_clr: one write port and two independent read ports (A, B).
// The write port has byte-lane enables. Each read port returns its data
// one cycle after the request, together with a valid strobe. When a read
// and a write hit the same address on the same edge, the read returns the
// newly written word. A clear sequencer writes CLR_VALUE to every word
// after reset and on clr_req; busy is high while that sweep runs.
module ram_dp_clr #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 9,
    parameter int                DEPTH     = 512,
    parameter logic [DATA_W-1:0] CLR_VALUE = {DATA_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_req,
    input  logic                  wr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     d_in,
    input  logic                  rd_en_a,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [DATA_W-1:0]     d_out_a,
    output logic                  rd_valid_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_W-1:0]     d_out_b,
    output logic                  rd_valid_b,
    output logic                  busy
);

    localparam int                NB       = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   d_out_a_q, d_out_a_d;
    logic [DATA_W-1:0]   d_out_b_q, d_out_b_d;
    logic                rd_valid_a_q, rd_valid_a_d;
    logic                rd_valid_b_q, rd_valid_b_d;
    logic [DATA_W-1:0]   mem_q [0:DEPTH-1];

    logic                wr_in_s, a_in_s, b_in_s;
    logic [ADDR_W-1:0]   wr_idx_s, a_idx_s, b_idx_s;
    logic [DATA_W-1:0]   merged_s;
    logic                wr_hit_a_s, wr_hit_b_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;

    // Range checks. An out-of-range address is replaced by 0 so that the
    // array is never indexed past its end; the caller ignores that result.
    always_comb begin
        wr_in_s  = ({1'b0, wr_addr}   < DEPTH_L);
        a_in_s   = ({1'b0, rd_addr_a} < DEPTH_L);
        b_in_s   = ({1'b0, rd_addr_b} < DEPTH_L);
        wr_idx_s = wr_in_s ? wr_addr   : {ADDR_W{1'b0}};
        a_idx_s  = a_in_s  ? rd_addr_a : {ADDR_W{1'b0}};
        b_idx_s  = b_in_s  ? rd_addr_b : {ADDR_W{1'b0}};
    end

    // Post-write word: enabled lanes come from d_in, the other lanes keep
    // the stored value. The write path and the write-first bypass both use it.
    always_comb begin
        merged_s = mem_q[wr_idx_s];
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                merged_s[8*i +: 8] = d_in[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = mem_q[wr_idx_s][8*i +: 8];
            end
        end
        wr_hit_a_s = wr && wr_in_s && a_in_s && (wr_addr == rd_addr_a);
        wr_hit_b_s = wr && wr_in_s && b_in_s && (wr_addr == rd_addr_b);
    end

    // Next-state logic: the clear sweep, write arbitration and read capture.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        d_out_a_d    = d_out_a_q;
        d_out_b_d    = d_out_b_q;
        rd_valid_a_d = 1'b0;
        rd_valid_b_d = 1'b0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = wr_idx_s;
        mem_wdata_s  = merged_s;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_ptr_q;
                mem_wdata_s = CLR_VALUE;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
                mem_we_s = wr && wr_in_s && (|wr_be);
                if (rd_en_a) begin
                    rd_valid_a_d = 1'b1;
                    if (!a_in_s) begin
                        d_out_a_d = {DATA_W{1'b0}};
                    end else if (wr_hit_a_s) begin
                        d_out_a_d = merged_s;
                    end else begin
                        d_out_a_d = mem_q[a_idx_s];
                    end
                end else begin
                    rd_valid_a_d = 1'b0;
                end
                if (rd_en_b) begin
                    rd_valid_b_d = 1'b1;
                    if (!b_in_s) begin
                        d_out_b_d = {DATA_W{1'b0}};
                    end else if (wr_hit_b_s) begin
                        d_out_b_d = merged_s;
                    end else begin
                        d_out_b_d = mem_q[b_idx_s];
                    end
                end else begin
                    rd_valid_b_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Control and output registers. Reset restarts the sweep from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= {ADDR_W{1'b0}};
            d_out_a_q    <= {DATA_W{1'b0}};
            d_out_b_q    <= {DATA_W{1'b0}};
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            d_out_a_q    <= d_out_a_d;
            d_out_b_q    <= d_out_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
        end
    end

    // Storage array. Reset does not change its contents.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign d_out_a    = d_out_a_q;
    assign d_out_b    = d_out_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
    assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed testbench for ram_dp_clr. Two instances receive the same inputs:
// one with the default DEPTH=512 and one with DEPTH=500, which gives
// addresses 500..511 that are out of range on the second instance.
module tb_ram_dp_clr;

    logic        clk;
    logic        reset;
    logic        clr_req;
    logic        wr;
    logic [1:0]  wr_be;
    logic [8:0]  wr_addr;
    logic [15:0] d_in;
    logic        rd_en_a;
    logic [8:0]  rd_addr_a;
    logic        rd_en_b;
    logic [8:0]  rd_addr_b;

    logic [15:0] d_out_a_l, d_out_b_l, d_out_a_s, d_out_b_s;
    logic        rd_valid_a_l, rd_valid_b_l, rd_valid_a_s, rd_valid_b_s;
    logic        busy_l, busy_s;

    int total;
    int bad;
    int c512;
    int c500;

    ram_dp_clr u_dut_l (
        .clk(clk), .reset(reset), .clr_req(clr_req), .wr(wr), .wr_be(wr_be),
        .wr_addr(wr_addr), .d_in(d_in),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .d_out_a(d_out_a_l), .rd_valid_a(rd_valid_a_l),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .d_out_b(d_out_b_l), .rd_valid_b(rd_valid_b_l),
        .busy(busy_l)
    );

    ram_dp_clr #(.DEPTH(500)) u_dut_s (
        .clk(clk), .reset(reset), .clr_req(clr_req), .wr(wr), .wr_be(wr_be),
        .wr_addr(wr_addr), .d_in(d_in),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .d_out_a(d_out_a_s), .rd_valid_a(rd_valid_a_s),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .d_out_b(d_out_b_s), .rd_valid_b(rd_valid_b_s),
        .busy(busy_s)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [8:0] a, input logic [15:0] d, input logic [1:0] be);
        wr = 1'b1; wr_addr = a; d_in = d; wr_be = be;
        step();
        wr = 1'b0; wr_be = 2'b00;
    endtask

    // Count busy cycles of both instances, starting from the current cycle.
    task automatic measure_busy(output int n512, output int n500);
        n512 = busy_l ? 1 : 0;
        n500 = busy_s ? 1 : 0;
        for (int i = 0; i < 2000 && (busy_l || busy_s); i++) begin
            step();
            if (busy_l) n512++;
            if (busy_s) n500++;
        end
        check("busy_timeout", {30'd0, busy_l, busy_s}, 32'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; clr_req = 1'b0; wr = 1'b0; wr_be = 2'b00; wr_addr = 9'd0; d_in = 16'h0000;
        rd_en_a = 1'b0; rd_addr_a = 9'd0; rd_en_b = 1'b0; rd_addr_b = 9'd0;

        // Reset state.
        step();
        reset = 1'b0;
        check("rst_busy", {31'd0, busy_l}, 32'd1);
        check("rst_valid", {28'd0, rd_valid_a_l, rd_valid_b_l, rd_valid_a_s, rd_valid_b_s}, 32'd0);
        check("rst_dout_a", {16'd0, d_out_a_l}, 32'h0);
        check("rst_dout_b", {16'd0, d_out_b_l}, 32'h0);

        // Sweep length after reset.
        measure_busy(c512, c500);
        check("sweep_len_512", c512, 32'd512);
        check("sweep_len_500", c500, 32'd500);

        // After the sweep every address reads back as zero.
        for (int a = 0; a < 512; a++) begin
            rd_en_a = 1'b1; rd_addr_a = 9'(a);
            step();
            check("clr_rd_l", {15'd0, rd_valid_a_l, d_out_a_l}, 32'h0001_0000);
            check("clr_rd_s", {15'd0, rd_valid_a_s, d_out_a_s}, 32'h0001_0000);
        end
        rd_en_a = 1'b0;

        // Basic writes, then simultaneous reads on A and B.
        do_write(9'd1,  16'hAAAA, 2'b11);
        do_write(9'd2,  16'h5555, 2'b11);
        do_write(9'd16, 16'h1234, 2'b11);
        rd_en_a = 1'b1; rd_addr_a = 9'd1; rd_en_b = 1'b1; rd_addr_b = 9'd2;
        step();
        check("rd_a1", {15'd0, rd_valid_a_l, d_out_a_l}, 32'h0001_AAAA);
        check("rd_b2", {15'd0, rd_valid_b_l, d_out_b_l}, 32'h0001_5555);
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        step();
        check("idle_valid_a", {31'd0, rd_valid_a_l}, 32'd0);
        check("hold_a", {16'd0, d_out_a_l}, 32'h0000_AAAA);
        check("hold_b", {16'd0, d_out_b_l}, 32'h0000_5555);
        rd_en_a = 1'b1; rd_addr_a = 9'd16;
        step();
        rd_en_a = 1'b0;
        check("rd_a16", {15'd0, rd_valid_a_l, d_out_a_l}, 32'h0001_1234);

        // Byte-lane enables.
        do_write(9'd3, 16'hFFFF, 2'b11);
        do_write(9'd3, 16'h1200, 2'b10);
        rd_en_b = 1'b1; rd_addr_b = 9'd3;
        step();
        rd_en_b = 1'b0;
        check("be_hi", {16'd0, d_out_b_l}, 32'h0000_12FF);
        do_write(9'd3, 16'h0000, 2'b00);
        rd_en_a = 1'b1; rd_addr_a = 9'd3;
        step();
        rd_en_a = 1'b0;
        check("be_none", {16'd0, d_out_a_l}, 32'h0000_12FF);

        // Write-first collision, with both ports reading the written address.
        do_write(9'd8, 16'h1234, 2'b11);
        wr = 1'b1; wr_addr = 9'd8; d_in = 16'hDEAD; wr_be = 2'b01;
        rd_en_b = 1'b1; rd_addr_b = 9'd8; rd_en_a = 1'b1; rd_addr_a = 9'd8;
        step();
        wr = 1'b0; wr_be = 2'b00; rd_en_b = 1'b0; rd_en_a = 1'b0;
        check("coll_b", {15'd0, rd_valid_b_l, d_out_b_l}, 32'h0001_12AD);
        check("coll_a", {16'd0, d_out_a_l}, 32'h0000_12AD);
        rd_en_a = 1'b1; rd_addr_a = 9'd8;
        step();
        rd_en_a = 1'b0;
        check("after_coll", {16'd0, d_out_a_l}, 32'h0000_12AD);

        // Out-of-range addresses on the DEPTH=500 instance.
        do_write(9'd505, 16'h5A5A, 2'b11);
        do_write(9'd499, 16'h7777, 2'b11);
        rd_en_a = 1'b1; rd_addr_a = 9'd505;
        step();
        check("oor_rd_s", {15'd0, rd_valid_a_s, d_out_a_s}, 32'h0001_0000);
        check("inr_505_l", {16'd0, d_out_a_l}, 32'h0000_5A5A);
        rd_addr_a = 9'd499;
        step();
        rd_en_a = 1'b0;
        check("rd_499_s", {16'd0, d_out_a_s}, 32'h0000_7777);
        check("rd_499_l", {16'd0, d_out_a_l}, 32'h0000_7777);

        // clr_req: accesses made during the sweep are ignored.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wr = 1'b1; wr_addr = 9'd1; d_in = 16'hBEEF; wr_be = 2'b11;
        rd_en_a = 1'b1; rd_addr_a = 9'd1; rd_en_b = 1'b1; rd_addr_b = 9'd2;
        c512 = busy_l ? 1 : 0;
        c500 = busy_s ? 1 : 0;
        for (int i = 0; i < 2000 && busy_l; i++) begin
            step();
            if (busy_l) begin
                c512++;
                check("sweep_va", {31'd0, rd_valid_a_l}, 32'd0);
                check("sweep_vb", {31'd0, rd_valid_b_l}, 32'd0);
            end
            if (busy_s) begin
                c500++;
            end else begin
                wr = 1'b0; wr_be = 2'b00; rd_en_a = 1'b0; rd_en_b = 1'b0;
            end
        end
        wr = 1'b0; wr_be = 2'b00; rd_en_a = 1'b0; rd_en_b = 1'b0;
        check("clr_len_512", c512, 32'd512);
        check("clr_len_500", c500, 32'd500);
        check("sweep_hold_l", {16'd0, d_out_a_l}, 32'h0000_7777);
        check("sweep_hold_s", {16'd0, d_out_a_s}, 32'h0000_7777);
        rd_en_a = 1'b1; rd_addr_a = 9'd1; rd_en_b = 1'b1; rd_addr_b = 9'd16;
        step();
        rd_en_a = 1'b0; rd_en_b = 1'b0;
        check("clr_at1", {15'd0, rd_valid_a_l, d_out_a_l}, 32'h0001_0000);
        check("clr_at16", {16'd0, d_out_b_l}, 32'h0000_0000);

        // Reset at sweep cycle 100 restarts the sweep from address 0.
        do_write(9'd20, 16'h4321, 2'b11);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (100) step();
        check("mid_busy", {31'd0, busy_l}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", {30'd0, busy_l, busy_s}, 32'd3);
        measure_busy(c512, c500);
        check("restart_len_512", c512, 32'd512);
        check("restart_len_500", c500, 32'd500);
        rd_en_a = 1'b1; rd_addr_a = 9'd20;
        step();
        rd_en_a = 1'b0;
        check("restart_at20", {15'd0, rd_valid_a_l, d_out_a_l}, 32'h0001_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_dp_clr.md
Name: ram_dp_clr

Overview:
- Parametrised successor to the 512x16 RAM: one write port and two independent read ports (A, B).
- Adds byte-lane write enables, registered reads with a valid strobe, and write-first bypass on same-address collisions.
- Adds a hardware clear sequencer that sweeps the whole array to CLR_VALUE after reset or on request.
- Sits as the general-purpose register/scratch memory of the 64KB RAM hierarchy.

Parameters:
- DATA_W, 16, data width in bits; must be a multiple of 8.
- ADDR_W, 9, address width.
- DEPTH, 512, number of words; 1 <= DEPTH <= 2**ADDR_W.
- CLR_VALUE, 0, word written to every location during a clear sweep.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; starts a clear sweep.
- clr_req  input  1  single-cycle request for a clear sweep.
- wr  input  1  write strobe.
- wr_be  input  DATA_W/8  byte-lane enables; bit i enables d_in[8i+7:8i].
- wr_addr  input  ADDR_W  write address.
- d_in  input  DATA_W  write data.
- rd_en_a  input  1  read request, port A.
- rd_addr_a  input  ADDR_W  read address, port A.
- d_out_a  output  DATA_W  read data, port A.
- rd_valid_a  output  1  d_out_a updated this cycle.
- rd_en_b  input  1  read request, port B.
- rd_addr_b  input  ADDR_W  read address, port B.
- d_out_b  output  DATA_W  read data, port B.
- rd_valid_b  output  1  d_out_b updated this cycle.
- busy  output  1  clear sweep in progress.

Behaviour:
- Reset (sampled at posedge clk):
  - d_out_a, d_out_b, rd_valid_a and rd_valid_b go to 0.
  - busy goes to 1, FSM enters CLEAR, clr_ptr goes to 0.
  - Array contents are not otherwise touched by reset.
- FSM states:
  - CLEAR: each cycle writes CLR_VALUE to mem[clr_ptr]. If clr_ptr == DEPTH-1, go to IDLE; otherwise clr_ptr increments.
  - IDLE: normal operation. clr_req=1 moves to CLEAR next cycle with clr_ptr=0.
- busy timing:
  - busy is high for exactly DEPTH cycles after the reset or clr_req edge.
  - busy drops in the cycle after the last sweep write.
- While in CLEAR:
  - wr, rd_en_a, rd_en_b and clr_req are ignored; writes are dropped.
  - rd_valid_x stays 0 and d_out_x holds its value.
- Reset asserted mid-sweep restarts the sweep at clr_ptr=0.
- Writes (IDLE):
  - At the posedge with wr=1, each lane i with wr_be[i]=1 is updated; the other lanes keep their old value.
  - wr=1 with wr_be all zero is a no-op.
  - wr_addr >= DEPTH: the write is dropped.
- Reads (IDLE), latency 1:
  - rd_en_x=1 at edge N makes d_out_x valid after edge N, and rd_valid_x=1 for that one cycle.
  - rd_en_x=0: rd_valid_x=0 next cycle and d_out_x holds its previous value.
  - rd_addr_x >= DEPTH returns 0 with rd_valid_x=1.
- Write-first collision:
  - If wr=1 and wr_addr == rd_addr_x at the same edge (both in range), d_out_x returns the post-write word (byte-merged new and old lanes).
  - Both ports may read the same address in the same cycle, with or without a collision.
- Port independence: A and B have no interaction; any combination of rd_en_a and rd_en_b in the same cycle is legal.
- No combinational path from any input to any output.

Test Plan:
- Sweep timing and contents: hold reset 1 cycle, then release → busy=1 for exactly 512 cycles, then 0. Reading every address on A then returns 0000 with rd_valid_a=1.
- Basic write and read:
  - Write AAAA@1, 5555@2, 1234@16, all with wr_be=11.
  - Read A@1 and B@2 in the same cycle → next cycle d_out_a=AAAA, d_out_b=5555, both valid.
  - Then read A@16 → 1234.
- Byte enables:
  - Write FFFF@3 with wr_be=11, then 1200@3 with wr_be=10.
  - Read @3 → 12FF.
  - A write with wr_be=00 leaves @3 unchanged.
- Write-first collision:
  - With @8=1234 and wr_be=01, write DEAD@8 while rd_en_b=1 and rd_addr_b=8 at the same edge → d_out_b=12AD next cycle.
  - A following read @8 → 12AD.
- Clear request and mid-sweep reset:
  - clr_req after the writes above → busy=1 for 512 cycles, with reads and writes ignored (rd_valid 0, a write to @1 is dropped). Afterwards @1=0000.
  - Assert reset at sweep cycle 100 → busy stays high for 512 more cycles.
- Out-of-range addresses: with DEPTH=500, write 5A5A@505 → dropped; read @505 → 0000 with rd_valid=1. Address 499 is fully usable.
